// File: rtl/dcache_ctrl_pkg.sv
// Shared constants and FSM state encoding for the L1 data cache controller.
package dcache_ctrl_pkg;

  localparam int unsigned OffW            = 5;
  localparam int unsigned DefaultLineBits = 256;
  localparam int unsigned WordW           = 32;
  localparam int unsigned WordSelW        = OffW - 2;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StAllocate  = 2'd2
  } dcache_state_e;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage for the direct-mapped data cache.
// Single index port shared by reads, full-line refills and word stores.
module dcache_sram
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned SETS      = 16,
  parameter int unsigned LINE_BITS = DefaultLineBits,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned TAG_W     = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [LINE_BITS-1:0] line_o,
  input  logic                 line_we_i,
  input  logic [TAG_W-1:0]     line_tag_i,
  input  logic [LINE_BITS-1:0] line_wdata_i,
  input  logic                 word_we_i,
  input  logic [WordSelW-1:0]  word_sel_i,
  input  logic [WordW-1:0]     word_wdata_i,
  input  logic                 clr_dirty_i
);

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (clr_dirty_i) begin
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Line contents survive reset; only the valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_wdata_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_sel_i*WordW +: WordW] <= word_wdata_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate L1 data cache controller.
// Defining DCACHE_STATS_EN adds saturating hit/miss counter outputs.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned SETS      = 16,
  parameter int unsigned LINE_BITS = DefaultLineBits,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [WordW-1:0]     wdata_i,
  output logic [WordW-1:0]     rdata_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = ADDR_W - IdxW - OffW;

  dcache_state_e        state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [LINE_BITS-1:0] mem_wdata_q;

  logic [ADDR_W-1:0]    cur_addr;
  logic [IdxW-1:0]      idx;
  logic [TagW-1:0]      tag;
  logic [WordSelW-1:0]  word;
  logic [TagW-1:0]      sram_tag;
  logic                 sram_valid;
  logic                 sram_dirty;
  logic [LINE_BITS-1:0] sram_line;
  logic                 hit;
  logic                 idle_req;
  logic                 unused_addr;

  // While a miss is in flight the captured address drives the arrays.
  assign cur_addr    = (state_q == StIdle) ? addr_i : addr_q;
  assign idx         = cur_addr[IdxW+OffW-1:OffW];
  assign tag         = cur_addr[ADDR_W-1:IdxW+OffW];
  assign word        = cur_addr[OffW-1:2];
  assign unused_addr = ^cur_addr[1:0];

  assign hit      = sram_valid && (sram_tag == tag);
  assign idle_req = (state_q == StIdle) && req_i;
  assign stall_o  = (state_q != StIdle) || (req_i && !hit);

  always_comb begin
    rdata_o = '0;
    if (idle_req && hit && !we_i) begin
      rdata_o = sram_line[word*WordW +: WordW];
    end
  end

  dcache_sram #(
    .SETS      (SETS),
    .LINE_BITS (LINE_BITS),
    .IDX_W     (IdxW),
    .TAG_W     (TagW)
  ) u_sram (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .idx_i        (idx),
    .tag_o        (sram_tag),
    .valid_o      (sram_valid),
    .dirty_o      (sram_dirty),
    .line_o       (sram_line),
    .line_we_i    ((state_q == StAllocate) && mem_ack_i),
    .line_tag_i   (tag),
    .line_wdata_i (mem_rdata_i),
    .word_we_i    (idle_req && hit && we_i),
    .word_sel_i   (word),
    .word_wdata_i (wdata_i),
    .clr_dirty_i  ((state_q == StWriteback) && mem_ack_i)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_i && !hit) begin
            addr_q    <= addr_i;
            mem_req_q <= 1'b1;
            if (sram_valid && sram_dirty) begin
              state_q     <= StWriteback;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {sram_tag, idx, {OffW{1'b0}}};
              mem_wdata_q <= sram_line;
            end else begin
              state_q    <= StAllocate;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag, idx, {OffW{1'b0}}};
            end
          end
        end
        StWriteback: begin
          // Request stays up; the refill is issued back-to-back on the ack edge.
          if (mem_ack_i) begin
            state_q     <= StAllocate;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {tag, idx, {OffW{1'b0}}};
            mem_wdata_q <= '0;
          end
        end
        StAllocate: begin
          if (mem_ack_i) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        retry_q;

  // The first IDLE cycle after a refill is the replayed access; skip it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
    end else begin
      retry_q <= (state_q == StAllocate) && mem_ack_i;
      if (idle_req && !retry_q) begin
        if (hit) begin
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, multi-cycle corner
// sequences and random accesses scored against a directory + flat-memory model.
module tb_dcache_ctrl;

  logic         clk;
  logic         rst_i;
  logic         req_i;
  logic         we_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic [31:0]  rdata_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_ctrl #(
    .SETS      (16),
    .LINE_BITS (256),
    .ADDR_W    (32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_line(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%064h, want 0x%064h", nm, act, exp);
    end
  endtask

  // ---------------- off-chip memory model ----------------
  logic [31:0] mem_words [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] waddr);
    if (waddr == 32'h11) return 32'h12345678;
    if (waddr == 32'h91) return 32'h0BADBEEF;
    return (waddr * 32'h9E3779B1) ^ 32'hA5A5A5A5;
  endfunction

  function automatic logic [31:0] backing(input logic [31:0] waddr);
    if (mem_words.exists(waddr)) return mem_words[waddr];
    return init_word(waddr);
  endfunction

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [255:0] wdata;
    logic         stable;
  } tx_t;

  tx_t txq[$];
  tx_t cur;
  int  mem_lat = 4;
  int  mcnt = 0;

  // Acks a request after mem_lat cycles of it being presented; an abandoned
  // request simply restarts the count.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_ack_i) mcnt = 0;
      mem_ack_i = 1'b0;
      if (mem_req_o === 1'b1) begin
        if (mcnt == 0) begin
          cur.addr = mem_addr_o; cur.we = mem_we_o; cur.wdata = mem_wdata_o; cur.stable = 1'b1;
        end else if (mem_addr_o !== cur.addr || mem_we_o !== cur.we ||
                     mem_wdata_o !== cur.wdata) begin
          cur.stable = 1'b0;
        end
        mcnt++;
        if (mcnt >= mem_lat) begin
          txq.push_back(cur);
          for (int k = 0; k < 8; k++) begin
            if (cur.we) mem_words[(cur.addr >> 2) + k] = cur.wdata[k*32 +: 32];
            else mem_rdata_i[k*32 +: 32] = backing((cur.addr >> 2) + k);
          end
          mem_ack_i = 1'b1;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic        dir_valid [16];
  logic        dir_dirty [16];
  logic [31:0] dir_line  [16];
  logic [31:0] ref_mem   [logic [31:0]];
  int          exp_hits;
  int          exp_misses;

  typedef struct {
    logic         hit;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    logic [31:0]  rd;
  } pred_t;

  function automatic logic [31:0] arch_word(input logic [31:0] waddr);
    if (ref_mem.exists(waddr)) return ref_mem[waddr];
    return backing(waddr);
  endfunction

  // Reset discards dirty lines, so their words revert to memory contents.
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      if (dir_valid[i] && dir_dirty[i])
        for (int k = 0; k < 8; k++) ref_mem.delete((dir_line[i] >> 2) + k);
      dir_valid[i] = 1'b0;
      dir_dirty[i] = 1'b0;
      dir_line[i]  = '0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output pred_t p);
    int unsigned idx;
    logic [31:0] line;
    idx       = (a >> 5) & 32'hF;
    line      = a & ~32'h1F;
    p.hit     = dir_valid[idx] && (dir_line[idx] == line);
    p.wb      = !p.hit && dir_valid[idx] && dir_dirty[idx];
    p.wb_addr = dir_line[idx];
    for (int k = 0; k < 8; k++) p.wb_line[k*32 +: 32] = arch_word((dir_line[idx] >> 2) + k);
    p.rd = w ? 32'h0 : arch_word(a >> 2);
    if (p.hit) exp_hits++; else exp_misses++;
    if (!p.hit) begin
      dir_valid[idx] = 1'b1;
      dir_dirty[idx] = 1'b0;
      dir_line[idx]  = line;
    end
    if (w) begin
      dir_dirty[idx]  = 1'b1;
      ref_mem[a >> 2] = d;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int stalls);
    txq.delete();
    @(negedge clk);
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    stalls = 0;
    #3;
    while (stall_o !== 1'b0 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #3;
    end
    rd = rdata_o;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic w, input logic [31:0] a,
                           input logic [31:0] d);
    pred_t       p;
    logic [31:0] rd;
    int          st;
    int          ntx;
    model_access(w, a, d, p);
    access(w, a, d, rd, st);
    ntx = p.hit ? 0 : (p.wb ? 2 : 1);
    check({nm, " rdata"}, rd, p.rd);
    check({nm, " stall cycles"}, st, p.hit ? 0 : 1 + ntx * mem_lat);
    check({nm, " mem transactions"}, txq.size(), ntx);
    if (ntx > 0 && txq.size() == ntx) begin
      if (p.wb) begin
        check({nm, " wb addr"}, txq[0].addr, p.wb_addr);
        check({nm, " wb we"}, {31'b0, txq[0].we}, 32'd1);
        check_line({nm, " wb data"}, txq[0].wdata, p.wb_line);
      end
      check({nm, " fill addr"}, txq[ntx-1].addr, a & ~32'h1F);
      check({nm, " fill we"}, {31'b0, txq[ntx-1].we}, 32'd0);
      for (int k = 0; k < ntx; k++) check({nm, " tx stable"}, {31'b0, txq[k].stable}, 32'd1);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_stall;
    int          exp_ntx;
    logic [31:0] tx0_addr;
    logic        tx0_we;
    logic [31:0] tx1_addr;
    logic [31:0] wb_w1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pred_t       p;
    logic [31:0] rd;
    int          st;
    int          n;

    vecs[0] = '{1'b0, 32'h044, 32'h0,        32'h12345678, 5, 1, 32'h040, 1'b0, 32'h0,   32'h0};
    vecs[1] = '{1'b1, 32'h044, 32'hCAFEF00D, 32'h0,        0, 0, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[2] = '{1'b0, 32'h044, 32'h0,        32'hCAFEF00D, 0, 0, 32'h0,   1'b0, 32'h0,   32'h0};
    vecs[3] = '{1'b0, 32'h244, 32'h0,        32'h0BADBEEF, 9, 2, 32'h040, 1'b1, 32'h240,
                32'hCAFEF00D};
    vecs[4] = '{1'b1, 32'h080, 32'hD00DFEED, 32'h0,        5, 1, 32'h080, 1'b0, 32'h0,   32'h0};
    vecs[5] = '{1'b0, 32'h080, 32'h0,        32'hD00DFEED, 0, 0, 32'h0,   1'b0, 32'h0,   32'h0};

    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall_o", {31'b0, stall_o}, 32'd0);
    check("reset mem_req_o", {31'b0, mem_req_o}, 32'd0);
    check("reset mem_we_o", {31'b0, mem_we_o}, 32'd0);
    check("reset mem_addr_o", mem_addr_o, 32'd0);
    check_line("reset mem_wdata_o", mem_wdata_o, 256'd0);
    check("reset rdata_o", rdata_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();

    // Directed vectors with hand-derived expectations, memory latency 4.
    mem_lat = 4;
    for (int i = 0; i < 6; i++) begin
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, p);
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, st);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d stall cycles", i), st, vecs[i].exp_stall);
      check($sformatf("vec%0d mem transactions", i), txq.size(), vecs[i].exp_ntx);
      if (txq.size() > 0) begin
        check($sformatf("vec%0d tx0 addr", i), txq[0].addr, vecs[i].tx0_addr);
        check($sformatf("vec%0d tx0 we", i), {31'b0, txq[0].we}, {31'b0, vecs[i].tx0_we});
        check($sformatf("vec%0d tx0 stable", i), {31'b0, txq[0].stable}, 32'd1);
      end
      if (txq.size() > 1) begin
        check($sformatf("vec%0d tx1 addr", i), txq[1].addr, vecs[i].tx1_addr);
        check($sformatf("vec%0d wb word1", i), txq[0].wdata[63:32], vecs[i].wb_w1);
      end
`ifdef DCACHE_STATS_EN
      if (i == 3) begin
        check("stats hit_cnt after 3 scenarios", hit_cnt_o, 32'd2);
        check("stats miss_cnt after 3 scenarios", miss_cnt_o, 32'd2);
      end
`endif
    end

    // Reset pulse during ALLOCATE abandons the refill.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h2A4;
    #3;
    check("abort miss stall", {31'b0, stall_o}, 32'd1);
    @(negedge clk);
    #3;
    check("abort alloc mem_req_o", {31'b0, mem_req_o}, 32'd1);
    check("abort alloc mem_we_o", {31'b0, mem_we_o}, 32'd0);
    check("abort alloc mem_addr_o", mem_addr_o, 32'h2A0);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("abort mem_req_o dropped", {31'b0, mem_req_o}, 32'd0);
    req_i = 1'b0;
    #1;
    check("abort stall_o idle", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();
    run_check("post-reset 0x244", 1'b0, 32'h244, 32'h0);
    run_check("post-reset 0x80 dirty lost", 1'b0, 32'h080, 32'h0);

    // req_i dropped mid-miss: refill still completes and installs the line.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h300;
    #3;
    check("drop miss stall", {31'b0, stall_o}, 32'd1);
    model_access(1'b0, 32'h300, 32'h0, p);
    @(negedge clk);
    req_i = 1'b0;
    n = 0;
    #3;
    while (mem_req_o !== 1'b0 && n < 50) begin
      n++;
      @(negedge clk);
      #3;
    end
    check("drop refill finished", {31'b0, mem_req_o}, 32'd0);
    check("drop stall released", {31'b0, stall_o}, 32'd0);
    run_check("drop retry hit", 1'b0, 32'h300, 32'h0);

    // Random traffic over a small address pool to mix hits, clean and dirty misses.
    for (int i = 0; i < 200; i++) begin
      logic        w;
      logic [31:0] a;
      mem_lat = $urandom_range(1, 3);
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
      run_check($sformatf("rnd%0d", i), w, a, $urandom);
    end

`ifdef DCACHE_STATS_EN
    check("stats hit_cnt final", hit_cnt_o, exp_hits);
    check("stats miss_cnt final", miss_cnt_o, exp_misses);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
